// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the stochastic divider stream scheduler.
package div_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WARMUP,
    ST_RUN,
    ST_DONE
  } state_t;

  // Fibonacci feedback masks (bit k set means stage k+1 is tapped) for maximal-length LFSRs
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      16:      return 32'h0000_D008;
      default: return 32'h0000_00B8;
    endcase
  endfunction

  // Ones count to signed quotient, clamped so a full-ones stream maps to max positive
  function automatic int sat_quotient(input int ones, input int unsigned w);
    int half;
    int v;
    half = 1 << (w - 1);
    v    = ones - half;
    if (v > half - 1) return half - 1;
    if (v < -half)    return -half;
    return v;
  endfunction

endpackage

// File: rtl/div_sched_lfsr.sv
// Maximal-length Fibonacci LFSR with enable; resets to seed 1 so it never reaches 0.
module div_sched_lfsr
  import div_sched_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic feedback;

  assign feedback = ^(value & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= W'(1);
    end else if (en) begin
      value <= {value[W-2:0], feedback};
    end
  end

endmodule

// File: rtl/div_stream_scheduler.sv
// Time-shares one bipolar stochastic divider among NREQ requesters.
// Optional build macro DIV_SCHED_ZERO_BYPASS_EN: zero dividends complete without streaming.
module div_stream_scheduler
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPLOG = 1,
  parameter int unsigned WARMUP = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_dividend,
  input  logic [NREQ*DATA_W-1:0]   req_divisor,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     div_clr,
  output logic                     div_dividend,
  output logic                     div_divisor,
  output logic [DEPLOG-1:0]        div_rand,
  input  logic                     div_quotient
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned L     = 1 << DATA_W;
  localparam int unsigned CNT_W = (DATA_W > $clog2(WARMUP)) ? DATA_W : $clog2(WARMUP);
  localparam logic [DATA_W-1:0] OFFSET = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_found;
  logic [DATA_W-1:0]   grant_a;
  logic [DATA_W-1:0]   grant_b;
  logic                bypass_c;
  logic                bypass;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W:0]     ones;
  logic [DATA_W:0]     ones_next;
  logic [DATA_W-1:0]   lfsr;
  logic [DATA_W-1:0]   lfsr_rev;
  logic                stream_next;

  // Round-robin pick: lowest requesting index at or after ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!grant_found && req_valid[(int'(ptr) + k) % int'(NREQ)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr) + k) % int'(NREQ));
      end
    end
  end

  assign grant_a = req_dividend[grant_idx*DATA_W +: DATA_W];
  assign grant_b = req_divisor[grant_idx*DATA_W +: DATA_W];

`ifdef DIV_SCHED_ZERO_BYPASS_EN
  assign bypass_c = (grant_a == '0);
`else
  assign bypass_c = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < int'(DATA_W); i++) begin
      lfsr_rev[i] = lfsr[DATA_W-1-i];
    end
  end

  // High when the next cycle is WARMUP or RUN; streams and LFSR step together
  assign stream_next = (state == ST_CLEAR && !bypass) || (state == ST_WARMUP) ||
                       (state == ST_RUN && cnt != CNT_W'(L - 1));
  assign ones_next   = ones + (DATA_W+1)'(div_quotient);

  div_sched_lfsr #(.W(DATA_W)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (stream_next),
    .value (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      req_ready    <= '0;
      op_a         <= '0;
      op_b         <= '0;
      bypass       <= 1'b0;
      cnt          <= '0;
      ones         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      div_clr      <= 1'b0;
      div_dividend <= 1'b0;
      div_divisor  <= 1'b0;
      div_rand     <= '0;
    end else begin
      req_ready    <= '0;
      div_clr      <= 1'b0;
      div_dividend <= stream_next && (op_a > lfsr);
      div_divisor  <= stream_next && (op_b > lfsr_rev);
      div_rand     <= stream_next ? lfsr[DATA_W-1 -: DEPLOG] : '0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            req_ready <= NREQ'(1) << grant_idx;
            op_a      <= grant_a ^ OFFSET;
            op_b      <= grant_b ^ OFFSET;
            rsp_id    <= grant_idx;
            ptr       <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            bypass    <= bypass_c;
            div_clr   <= !bypass_c;
            state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt  <= '0;
          ones <= '0;
          if (bypass) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            state     <= ST_DONE;
          end else begin
            state <= ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WARMUP - 1)) begin
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          ones <= ones_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(L - 1)) begin
            rsp_valid <= 1'b1;
            rsp_data  <= DATA_W'(sat_quotient(int'(ones_next), DATA_W));
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_stream_scheduler.sv
// Self-checking bench for div_stream_scheduler with a behavioural stochastic divider model.
// Honours DIV_SCHED_ZERO_BYPASS_EN for the zero-dividend expectations.
module tb_div_stream_scheduler;

  localparam int LAT = 2 + 8 + 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        div_clr;
  logic        div_dividend;
  logic        div_divisor;
  logic [0:0]  div_rand;
  logic        div_quotient = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [3:0] last_ready;
  int clr_cnt, grant_cnt, onehot_bad;
  int grants[$];

  // Divider model state
  int  mode = 0;
  int  na, nb, n, nq, m;
  real ea, eb, tgt;
  bit  qbit;

  div_stream_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .div_clr      (div_clr),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_rand     (div_rand),
    .div_quotient (div_quotient)
  );

  always #5 clk = ~clk;

  // Sigma-delta divider: tracks the bipolar ratio of the observed input streams
  always @(negedge clk) begin
    if (rst || div_clr) begin
      na = 0; nb = 0; n = 0; nq = 0; m = 0;
      div_quotient = (mode == 1);
    end else begin
      n++;
      na += int'(div_dividend);
      nb += int'(div_divisor);
      ea = 2.0 * na / n - 1.0;
      eb = 2.0 * nb / n - 1.0;
      if (eb > -0.05 && eb < 0.05) tgt = 0.0;
      else tgt = ea / eb;
      if (tgt > 1.0) tgt = 1.0;
      if (tgt < -1.0) tgt = -1.0;
      if (m == 0) qbit = (tgt > 0.0);
      else qbit = ((2.0 * nq / m - 1.0) < tgt);
      m++;
      if (qbit) nq++;
      div_quotient = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : qbit;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock; samples grants and clears the granted requester's valid
  task automatic step();
    @(posedge clk);
    #1;
    last_ready = req_ready;
    if (div_clr) clr_cnt++;
    if (req_ready != 4'b0) begin
      grant_cnt++;
      if (!$onehot(req_ready)) onehot_bad++;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          grants.push_back(i);
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b);
    req_dividend = {4{a}};
    req_divisor  = {4{b}};
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Serve jobs back to back, recording each response value
  task automatic serve(input int jobs, output int first_data);
    int lat;
    first_data = 0;
    for (int j = 0; j < jobs; j++) begin
      wait_rsp(lat);
      check($sformatf("serve%0d_done", j), int'(rsp_valid), 1);
      if (j == 0) first_data = $signed(rsp_data);
      handshake();
    end
  endtask

  function automatic int out_bits();
    return int'({req_ready, rsp_valid, rsp_id, rsp_data, div_clr, div_dividend, div_divisor, div_rand});
  endfunction

  typedef struct {
    logic [3:0] mask;
    logic [7:0] a;
    logic [7:0] b;
    int         mode;
    int         exp_id;
    int         lo;
    int         hi;
    int         exp_lat;
    int         exp_clr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, id, data, snap_id, snap_data, bad;
    int exp_order[4];

    vecs[0] = '{4'b0001, 8'd32,   8'd64,   0, 0,   52,   76, LAT, 1};
    vecs[1] = '{4'b0010, 8'd100,  8'd50,   1, 1,  127,  127, LAT, 1};
    vecs[2] = '{4'b0100, 8'h9C,   8'd50,   2, 2, -128, -128, LAT, 1};
    vecs[3] = '{4'b1000, 8'hE0,   8'd64,   0, 3,  -76,  -52, LAT, 1};
    vecs[4] = '{4'b0001, 8'd32,   8'hC0,   0, 0,  -76,  -52, LAT, 1};
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    vecs[5] = '{4'b0010, 8'd0,    8'd64,   0, 1,    0,    0,   2, 0};
`else
    vecs[5] = '{4'b0010, 8'd0,    8'd64,   0, 1,  -12,   12, LAT, 1};
`endif

    rst = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b0;
    set_ops(8'd0, 8'd0);
    #1;
    check("reset_outputs", out_bits(), 0);
    step();
    step();
    rst = 1'b0;

    // Table-driven jobs
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      clr_cnt = 0;
      grant_cnt = 0;
      onehot_bad = 0;
      set_ops(vecs[i].a, vecs[i].b);
      req_valid = vecs[i].mask;
      wait_rsp(lat);
      id = rsp_id;
      data = $signed(rsp_data);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_id", i), id, vecs[i].exp_id);
      check_range($sformatf("v%0d_data", i), data, vecs[i].lo, vecs[i].hi);
      check($sformatf("v%0d_grant_pulses", i), grant_cnt, 1);
      check($sformatf("v%0d_clr_pulses", i), clr_cnt, vecs[i].exp_clr);
      check($sformatf("v%0d_onehot", i), onehot_bad, 0);
      if (i == 0) begin
        check_range("v0_dividend_density", na, 155, 170);
        check_range("v0_divisor_density", nb, 190, 205);
      end
      handshake();
      check($sformatf("v%0d_rsp_cleared", i), int'(rsp_valid), 0);
    end
    mode = 0;

    // Response held 50 cycles with another request pending
    set_ops(8'd32, 8'd64);
    req_valid = 4'b0100;
    wait_rsp(lat);
    check("stall_rsp_valid", int'(rsp_valid), 1);
    check("stall_id", int'(rsp_id), 2);
    snap_id = rsp_id;
    snap_data = rsp_data;
    req_valid[0] = 1'b1;
    grant_cnt = 0;
    bad = 0;
    repeat (50) begin
      step();
      if (!rsp_valid || int'(rsp_id) != snap_id || int'(rsp_data) != snap_data) bad++;
    end
    check("stall_stable", bad, 0);
    check("stall_no_grant", grant_cnt, 0);
    handshake();
    check("hs_cycle_no_grant", int'(last_ready), 0);
    check("hs_rsp_dropped", int'(rsp_valid), 0);
    step();
    check("post_hs_grant", int'(last_ready), 1);
    wait_rsp(lat);
    check("post_hs_id", int'(rsp_id), 0);
    handshake();

    // Reset in the middle of RUN
    req_valid = 4'b1000;
    repeat (100) step();
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", out_bits(), 0);
    step();
    step();
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      step();
      if (rsp_valid) bad++;
    end
    check("aborted_no_rsp", bad, 0);

    // Arbitration: 0 and 2 together from a fresh pointer, then all four
    grants.delete();
    set_ops(8'd32, 8'd64);
    req_valid = 4'b0101;
    serve(2, data);
    check_range("recovery_data", data, 52, 76);
    check("rr_pair_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("rr_pair_first", grants[0], 0);
      check("rr_pair_second", grants[1], 2);
    end
    grants.delete();
    req_valid = 4'b1111;
    serve(4, data);
    exp_order = '{3, 0, 1, 2};
    check("rr_all_count", grants.size(), 4);
    if (grants.size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("rr_all_%0d", k), grants[k], exp_order[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
